// File: rtl/conv_window_engine.sv
// Serial KxK window engine: conv MAC, max-pool or sum-pool, one tap per cycle.
// Optional build macro CONV_SIGNED_EN: signed kernel and ReLU clamp for conv MAC.
module conv_window_engine #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [K*K*DATA_W-1:0]     image_flat,
    input  logic [K*K*DATA_W-1:0]     kernel_flat,
    input  logic [1:0]                mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          result,
    output logic                      busy
);

    localparam int N     = K * K;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
`ifdef CONV_SIGNED_EN
    localparam int AW    = ACC_W + 1;
`else
    localparam int AW    = ACC_W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [IDX_W-1:0]        idx_r;
    logic [AW-1:0]           acc_r;
    logic [AW-1:0]           acc_nxt_s;
    logic [N*DATA_W-1:0]     img_r;
    logic [N*DATA_W-1:0]     ker_r;
    logic [1:0]              mode_r;
    logic [DATA_W-1:0]       img_tap_s;
    logic [DATA_W-1:0]       ker_tap_s;
    logic [AW-1:0]           img_ext_s;
    logic [AW-1:0]           prod_s;
    logic [OUT_W-1:0]        res_s;
    logic                    last_tap_s;

    // Clamp any value that does not fit in OUT_W bits to all ones.
    function automatic logic [OUT_W-1:0] sat_f(input logic [AW-1:0] v);
        if (|v[AW-1:OUT_W]) begin
            sat_f = {OUT_W{1'b1}};
        end else begin
            sat_f = v[OUT_W-1:0];
        end
    endfunction

    assign in_ready   = (state_r == ST_IDLE) && !rst;
    assign busy       = (state_r != ST_IDLE);
    assign last_tap_s = (idx_r == IDX_W'(N - 1));
    assign img_tap_s  = img_r[idx_r*DATA_W +: DATA_W];
    assign ker_tap_s  = ker_r[idx_r*DATA_W +: DATA_W];
    assign img_ext_s  = {{(AW-DATA_W){1'b0}}, img_tap_s};

`ifdef CONV_SIGNED_EN
    // Image stays unsigned, kernel is two's complement; low AW bits are exact.
    assign prod_s = $signed(img_ext_s) * $signed({{(AW-DATA_W){ker_tap_s[DATA_W-1]}}, ker_tap_s});
`else
    assign prod_s = img_ext_s * {{(AW-DATA_W){1'b0}}, ker_tap_s};
`endif

    // Next-state decode for the window sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    state_nxt_s = ST_ACC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (last_tap_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            ST_DONE: state_nxt_s = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Per-tap accumulator update for the latched mode.
    always_comb begin
        acc_nxt_s = acc_r;
        case (mode_r)
            2'b00: acc_nxt_s = acc_r + prod_s;
            2'b01: begin
                if (img_ext_s > acc_r) begin
                    acc_nxt_s = img_ext_s;
                end else begin
                    acc_nxt_s = acc_r;
                end
            end
            2'b10:   acc_nxt_s = acc_r + img_ext_s;
            default: acc_nxt_s = acc_r;
        endcase
    end

    // Final result formatting; max-pool bypasses the shift.
    always_comb begin
        res_s = {OUT_W{1'b0}};
        case (mode_r)
            2'b00: begin
`ifdef CONV_SIGNED_EN
                if (acc_r[AW-1]) begin
                    res_s = {OUT_W{1'b0}};
                end else begin
                    res_s = sat_f(acc_r >> SHIFT);
                end
`else
                res_s = sat_f(acc_r >> SHIFT);
`endif
            end
            2'b01:   res_s = sat_f(acc_r);
            2'b10:   res_s = sat_f(acc_r >> SHIFT);
            default: res_s = {OUT_W{1'b0}};
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Window capture, tap index and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_r  <= {(N*DATA_W){1'b0}};
            ker_r  <= {(N*DATA_W){1'b0}};
            mode_r <= 2'b00;
            acc_r  <= {AW{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        img_r  <= image_flat;
                        ker_r  <= kernel_flat;
                        mode_r <= mode;
                        acc_r  <= {AW{1'b0}};
                        idx_r  <= {IDX_W{1'b0}};
                    end
                end
                ST_ACC: begin
                    acc_r <= acc_nxt_s;
                    if (last_tap_s) begin
                        idx_r <= {IDX_W{1'b0}};
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    // Registered result and output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= {OUT_W{1'b0}};
            out_valid <= 1'b0;
        end else begin
            case (state_r)
                ST_DONE: begin
                    result    <= res_s;
                    out_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_engine.sv
// Randomised self-checking bench for conv_window_engine against an arithmetic reference model.
// A second instance with SHIFT=2 shares the stimulus.
module tb_conv_window_engine;

    localparam int DATA_W = 8;
    localparam int K      = 3;
    localparam int N      = K * K;
    localparam int ACC_W  = 24;
    localparam int OUT_W  = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   out_ready;
    logic [N*DATA_W-1:0]    image_flat;
    logic [N*DATA_W-1:0]    kernel_flat;
    logic [1:0]             mode;
    logic                   in_ready, out_valid, busy;
    logic [OUT_W-1:0]       result;
    logic                   in_ready2, out_valid2, busy2;
    logic [OUT_W-1:0]       result2;

    int n_checks = 0;
    int n_fail   = 0;

    conv_window_engine #(.DATA_W(DATA_W), .K(K), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .image_flat(image_flat), .kernel_flat(kernel_flat), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    conv_window_engine #(.DATA_W(DATA_W), .K(K), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(2)) dut_sh2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .image_flat(image_flat), .kernel_flat(kernel_flat), .mode(mode),
        .out_valid(out_valid2), .out_ready(out_ready), .result(result2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic over the taps, then clamp, shift and saturate.
    function automatic longint ref_result(input logic [1:0] m, input logic [N*DATA_W-1:0] img,
                                          input logic [N*DATA_W-1:0] ker, input int sh);
        longint acc, a, b;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            a = longint'(img[i*DATA_W +: DATA_W]);
`ifdef CONV_SIGNED_EN
            b = longint'($signed(ker[i*DATA_W +: DATA_W]));
`else
            b = longint'(ker[i*DATA_W +: DATA_W]);
`endif
            if (m == 2'd0) acc = acc + a * b;
            else if (m == 2'd1) acc = (a > acc) ? a : acc;
            else if (m == 2'd2) acc = acc + a;
        end
        if (m == 2'd3) return 0;
        if (acc < 0) acc = 0;
        if (m != 2'd1) acc = acc >>> sh;
        if (acc > 255) acc = 255;
        return acc;
    endfunction

    function automatic logic [N*DATA_W-1:0] seq_flat(input int start, input int step);
        logic [N*DATA_W-1:0] f;
        for (int i = 0; i < N; i++) f[i*DATA_W +: DATA_W] = DATA_W'(start + i * step);
        return f;
    endfunction

    function automatic logic [N*DATA_W-1:0] rand_flat(input int maxv);
        logic [N*DATA_W-1:0] f;
        for (int i = 0; i < N; i++) f[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, maxv));
        return f;
    endfunction

    // One window: accept, check latency and both results, optional backpressure, release.
    task automatic run_window(input string tag, input logic [1:0] m, input logic [N*DATA_W-1:0] img,
                              input logic [N*DATA_W-1:0] ker, input int stall);
        int     w, lat;
        longint exp0, exp2;
        exp0 = ref_result(m, img, ker, 0);
        exp2 = ref_result(m, img, ker, 2);
        image_flat  = img;
        kernel_flat = ker;
        mode        = m;
        in_valid    = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 50) begin
            check_eq({tag, "_accept_timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid    = 1'b0;
        mode        = 2'($urandom_range(0, 3));
        image_flat  = rand_flat(255);
        kernel_flat = rand_flat(255);
        check_eq({tag, "_busy"}, longint'(busy), 1);
        check_eq({tag, "_in_ready_low"}, longint'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check_eq({tag, "_latency"}, lat, N + 1);
        check_eq({tag, "_result"}, longint'(result), exp0);
        check_eq({tag, "_result_sh2"}, longint'(result2), exp2);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check_eq({tag, "_hold_valid"}, longint'(out_valid), 1);
            check_eq({tag, "_hold_result"}, longint'(result), exp0);
            check_eq({tag, "_hold_in_ready"}, longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_release_valid"}, longint'(out_valid), 0);
        check_eq({tag, "_release_in_ready"}, longint'(in_ready), 1);
        check_eq({tag, "_release_busy"}, longint'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[N] = '{3, 200, 7, 0, 9, 199, 1, 2, 4};
        logic [N*DATA_W-1:0] maxp;
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 2'b00;
        image_flat = '0; kernel_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", longint'(out_valid), 0);
        check_eq("rst_result", longint'(result), 0);
        check_eq("rst_busy", longint'(busy), 0);
        check_eq("rst_in_ready", longint'(in_ready), 0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", longint'(in_ready), 1);

        for (int i = 0; i < N; i++) maxp[i*DATA_W +: DATA_W] = DATA_W'(vals[i]);
        run_window("mac_sat", 2'd0, seq_flat(1, 1), seq_flat(1, 1), 0);
        run_window("mac_ones", 2'd0, seq_flat(1, 1), seq_flat(1, 0), 0);
        run_window("maxpool", 2'd1, maxp, rand_flat(255), 0);
        run_window("sumpool", 2'd2, seq_flat(1, 1), rand_flat(255), 0);
        run_window("reserved", 2'd3, rand_flat(255), rand_flat(255), 0);
        run_window("backpressure", 2'd2, seq_flat(10, 3), seq_flat(0, 0), 5);
        run_window("after_bp", 2'd1, seq_flat(5, 7), seq_flat(0, 0), 0);
        run_window("mac_neg_ker", 2'd0, seq_flat(1, 1), seq_flat(255, 0), 0);

        // Reset in the middle of accumulation discards the window.
        image_flat = seq_flat(1, 1); kernel_flat = seq_flat(1, 1); mode = 2'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", longint'(out_valid), 0);
        check_eq("midrst_result", longint'(result), 0);
        check_eq("midrst_busy", longint'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("midrst_no_output", seen, 0);
        run_window("after_rst_sum2", 2'd2, seq_flat(2, 0), rand_flat(255), 0);

        for (int r = 0; r < 24; r++) begin
            logic [1:0] m;
            m = 2'($urandom_range(0, 3));
            if (r % 2 == 0) run_window("rand_small", m, rand_flat(7), rand_flat(7), $urandom_range(0, 3));
            else run_window("rand_full", m, rand_flat(255), rand_flat(255), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_engine.md
Name: conv_window_engine

Overview:
Parametrised successor to the fixed 3x3 compute cell. It accepts one KxK image window plus kernel per valid/ready handshake and processes it serially, one tap per cycle. Three operations are available: convolution MAC, max-pool, and sum-pool. The result is shifted, saturated, and returned over an output valid/ready handshake. It sits between the window line-buffer and the feature-map writer in the conv datapath.

Parameters:
DATA_W, 8, width of each image and kernel element
K, 3, window side; N = K*K taps
ACC_W, 24, accumulator width; must hold N*(2^DATA_W-1)^2
OUT_W, 8, result width
SHIFT, 0, right shift applied before saturation (modes 00 and 10 only)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  window/kernel/mode presented
in_ready  out  1  engine can accept a window
image_flat  in  N*DATA_W  element i at bits [i*DATA_W +: DATA_W]
kernel_flat  in  N*DATA_W  same packing as image_flat
mode  in  2  00 conv MAC, 01 max-pool, 10 sum-pool, 11 reserved
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  OUT_W  saturated result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset state: IDLE, out_valid=0, result=0, busy=0, accumulator=0, tap index=0.
- in_ready = (state==IDLE) && !rst.
- FSM: IDLE -> ACC -> DONE -> HOLD -> IDLE.
- IDLE:
  - On in_valid && in_ready at edge t0, register image_flat, kernel_flat and mode; clear acc; set idx=0; go to ACC.
  - Inputs are not sampled again until the next IDLE.
- ACC: edges t1..tN each process tap idx, then idx++. Per mode:
  - 00: acc += img[idx]*ker[idx], unsigned, full ACC_W.
  - 01: acc = max(acc, img[idx]), unsigned.
  - 10: acc += img[idx].
  - 11: acc unchanged (stays 0).
  - At tN (idx==N-1) go to DONE.
- DONE: at edge tN+1:
  - result = sat(acc >> SHIFT) for modes 00/10; sat(acc) for 01; 0 for 11.
  - sat(): any value > 2^OUT_W-1 becomes all ones.
  - out_valid rises at tN+1; go to HOLD.
- HOLD:
  - result and out_valid are held stable while out_ready=0.
  - On out_valid && out_ready at an edge: out_valid=0, go to IDLE; in_ready is high the following cycle.
- Latency: out_valid asserts N+1 cycles after the acceptance edge. Minimum initiation interval is N+3 cycles.
- in_valid during ACC/DONE/HOLD is ignored. The upstream holds it, and the window is accepted on return to IDLE.
- Reset mid-operation (any state): all state and outputs return to reset values immediately. A partial window is discarded and no out_valid is produced for it.
- A mode value is latched per window; changes on the mode port after acceptance have no effect.

Optional Feature:
CONV_SIGNED_EN
- Defined:
  - Kernel elements are two's complement; image elements stay unsigned.
  - Mode 00 uses a signed ACC_W+1 accumulator.
  - In DONE, negative values clamp to 0 (ReLU), then arithmetic shift, then positive saturation.
  - Modes 01/10/11 are unchanged.
- Undefined: all arithmetic is unsigned, as described above.

Test Plan:
1. mode=00, image=1..9, kernel=1..9 -> acc 285, result=255 (saturated); out_valid exactly 10 cycles after acceptance. Same again with kernel all 1 -> result=45.
2. mode=01, image={3,200,7,0,9,199,1,2,4} -> result=200. mode=10, image=1..9 -> result=45. With SHIFT=2: mode 10 -> 11, mode 01 -> 200 (shift not applied).
3. mode=11, any data -> result=0, with the same latency as the other modes.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and out_valid stable, in_ready=0, a new in_valid is not accepted. Raise out_ready -> out_valid drops next edge, in_ready=1 the cycle after, and the queued window is accepted.
5. Assert rst for 1 cycle at ACC idx=4 -> out_valid=0, result=0, busy=0 immediately. A following mode=10 window of all 2s -> result=18.
6. With CONV_SIGNED_EN: mode=00, image=1..9, kernel all 8'hFF -> result=0. Without the macro, the same stimulus -> result=255.
